fg_fetch_responder: RTL and testbench
=====================================

Name: fg_fetch_responder

Overview:
- Foreground memory front-end that answers the compositing pipeline's per-pixel foreground requests.
- Converts each signed request coordinate into an SRAM read and returns the pixel, or a skip, exactly FETCH_DELAY clocks after the request.
- Interleaves foreground-capture writes onto the same single-port SRAM during cycles with no read, buffering them in a small FIFO.

Parameters:
- PRECISION, 11, unsigned coordinate width; request coordinates are PRECISION+1 bits signed.
- PIXEL_SIZE, 16, pixel width (RGB565).
- RESOLUTION_X, 800, foreground frame width.
- RESOLUTION_Y, 600, foreground frame height.
- ADDR_WIDTH, 19, SRAM word address width.
- SRAM_READ_LATENCY, 2, cycles from registered sram_addr to valid sram_rdata.
- FETCH_DELAY, 6, request-to-response latency; must be >= SRAM_READ_LATENCY+3.
- WR_FIFO_DEPTH, 8, write FIFO entries (power of two).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  a request slot this cycle; always produces a response
- req_active  in  1  request wants real data; low means the response is a skip
- req_x  in  PRECISION+1  signed foreground x
- req_y  in  PRECISION+1  signed foreground y
- resp_ready  out  1  response valid
- resp_skip  out  1  no foreground pixel for this response
- resp_pixel  out  PIXEL_SIZE  pixel data; 0 when skip
- wr_valid  in  1  capture write offered
- wr_ready  out  1  FIFO not full; combinational from count
- wr_x  in  PRECISION  write x
- wr_y  in  PRECISION  write y
- wr_pixel  in  PIXEL_SIZE  write data
- wr_drop_count  out  16  saturating count of rejected or out-of-range writes
- sram_addr  out  ADDR_WIDTH  registered address
- sram_oe  out  1  registered read strobe
- sram_we  out  1  registered write strobe
- sram_wdata  out  PIXEL_SIZE  registered write data
- sram_rdata  in  PIXEL_SIZE  read data

Behaviour:
- Reset: all outputs 0, FIFO empty, all pipeline valid bits cleared, wr_drop_count=0. In-flight requests are discarded; no resp_ready is produced for requests sampled before or during rst.
- Timing convention: "edge E" is the clock edge that samples the request; outputs registered at edge E+n are "at E+n".
- E+1, stage 1: register x, y, valid.
  - hit = req_active AND 0<=x<RESOLUTION_X AND 0<=y<RESOLUTION_Y.
  - Both coordinates are compared as signed values; a negative coordinate is never a hit.
- E+2, stage 2: sram_addr = y*RESOLUTION_X + x, computed at ADDR_WIDTH.
  - sram_oe = valid AND hit.
  - No SRAM access when not hit.
- sram_rdata is valid SRAM_READ_LATENCY cycles after stage 2 and is captured into the data delay line.
- Valid, skip and data are carried by delay lines.
- resp_ready asserts at E+FETCH_DELAY for exactly 1 cycle per req_valid, whether skip or not; back-to-back requests give back-to-back responses.
- resp_skip = NOT hit; resp_pixel = 0 whenever resp_skip or NOT resp_ready.
- Write path:
  - Push when wr_valid AND wr_ready.
  - Writes with wr_x>=RESOLUTION_X or wr_y>=RESOLUTION_Y are not pushed and increment wr_drop_count.
  - wr_valid while full is dropped and increments wr_drop_count.
  - wr_drop_count saturates at 16'hFFFF.
- Bus arbitration:
  - Reads have absolute priority.
  - Only in a cycle where stage 2 issues no read (stage 2 invalid or not hit) and the FIFO is non-empty: pop one entry and drive sram_we=1, sram_addr=wr_y*RESOLUTION_X+wr_x, sram_wdata.
  - sram_oe and sram_we are never high together.
- FIFO push and pop in the same cycle:
  - Allowed when not full; count is unchanged.
  - When full, wr_ready=0 from the current count, so the push is rejected even though a pop occurs.
- Writes may starve indefinitely during continuous hits; this is acceptable, as blanking provides idle slots.

Test Plan:
- Single request x=0, y=0, active, SRAM word0=16'hF800, rst released -> resp_ready at E+6 with skip=0, pixel=16'hF800; sram_oe at E+2 with addr 0.
- Request x=799, y=599 -> sram_addr=479999. Request x=800, y=0 -> no sram_oe; resp at E+6 with skip=1, pixel=0. Request x=-1 (12'hFFF) -> skip=1.
- 20 consecutive req_valid with alternating active -> 20 consecutive resp_ready cycles starting E+6, skip pattern alternating; sram_oe never overlaps sram_we.
- Push 9 writes while reads saturate the bus -> wr_ready drops after 8; 9th increments wr_drop_count to 1. Stop reads -> 8 sram_we pulses in FIFO order; then read-back of each address returns the written data.
- Assert rst for 1 cycle 3 cycles after 2 requests -> no resp_ready is ever produced for them; FIFO empty; wr_drop_count=0.
- Hold wr_valid with wr_x=900 for 70000 cycles -> wr_drop_count saturates at 16'hFFFF; no sram_we.

Source files
------------

// File: rtl/fg_fetch_responder.sv
// Foreground fetch responder: fixed-latency pixel reads from a single-port SRAM,
// with capture writes buffered in a FIFO and slotted into cycles without a read.
module fg_fetch_responder #(
  parameter int PRECISION         = 11,
  parameter int PIXEL_SIZE        = 16,
  parameter int RESOLUTION_X      = 800,
  parameter int RESOLUTION_Y      = 600,
  parameter int ADDR_WIDTH        = 19,
  parameter int SRAM_READ_LATENCY = 2,
  parameter int FETCH_DELAY       = 6,
  parameter int WR_FIFO_DEPTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_active,
  input  logic [PRECISION:0]    req_x,
  input  logic [PRECISION:0]    req_y,
  output logic                  resp_ready,
  output logic                  resp_skip,
  output logic [PIXEL_SIZE-1:0] resp_pixel,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [PRECISION-1:0]  wr_x,
  input  logic [PRECISION-1:0]  wr_y,
  input  logic [PIXEL_SIZE-1:0] wr_pixel,
  output logic [15:0]           wr_drop_count,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_oe,
  output logic                  sram_we,
  output logic [PIXEL_SIZE-1:0] sram_wdata,
  input  logic [PIXEL_SIZE-1:0] sram_rdata
);

  // Valid/hit line runs from stage 2 to the response register; data line from SRAM capture to it.
  localparam int LP_DL = FETCH_DELAY - 3;
  localparam int LP_DD = FETCH_DELAY - 2 - SRAM_READ_LATENCY;
  localparam int LP_PW = $clog2(WR_FIFO_DEPTH);

  localparam logic [PRECISION-1:0]  LP_RES_X  = PRECISION'(RESOLUTION_X);
  localparam logic [PRECISION-1:0]  LP_RES_Y  = PRECISION'(RESOLUTION_Y);
  localparam logic [ADDR_WIDTH-1:0] LP_ROW    = ADDR_WIDTH'(RESOLUTION_X);
  localparam logic [LP_PW:0]        LP_DEPTH  = (LP_PW+1)'(WR_FIFO_DEPTH);
  localparam logic [LP_PW:0]        LP_CNT_1  = (LP_PW+1)'(1);
  localparam logic [LP_PW-1:0]      LP_PTR_1  = LP_PW'(1);

  logic                  r_in_valid, r_in_active;
  logic [PRECISION:0]    r_in_x, r_in_y;
  logic                  r_s1_valid, r_s1_hit;
  logic [PRECISION-1:0]  r_s1_x, r_s1_y;
  logic                  r_s2_valid, r_s2_hit;
  logic [LP_DL-1:0]      r_vdl_v, r_vdl_h;
  logic [PIXEL_SIZE-1:0] r_ddl [0:LP_DD-1];

  logic                  r_resp_ready, r_resp_skip;
  logic [PIXEL_SIZE-1:0] r_resp_pixel;
  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic                  r_sram_oe, r_sram_we;
  logic [PIXEL_SIZE-1:0] r_sram_wdata;

  logic [ADDR_WIDTH-1:0] r_fifo_addr [0:WR_FIFO_DEPTH-1];
  logic [PIXEL_SIZE-1:0] r_fifo_data [0:WR_FIFO_DEPTH-1];
  logic [LP_PW-1:0]      r_wptr, r_rptr;
  logic [LP_PW:0]        r_count;
  logic [15:0]           r_drop_cnt;

  logic                  w_in_hit;
  logic                  w_rd_req;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic                  w_full, w_wr_in_range, w_push, w_pop, w_drop;

  // Sign bit set means negative, which can never land inside the frame.
  assign w_in_hit = r_in_active
                  && !r_in_x[PRECISION] && (r_in_x[PRECISION-1:0] < LP_RES_X)
                  && !r_in_y[PRECISION] && (r_in_y[PRECISION-1:0] < LP_RES_Y);

  assign w_rd_req  = r_s1_valid && r_s1_hit;
  assign w_rd_addr = ADDR_WIDTH'(r_s1_y) * LP_ROW + ADDR_WIDTH'(r_s1_x);
  assign w_wr_addr = ADDR_WIDTH'(wr_y) * LP_ROW + ADDR_WIDTH'(wr_x);

  assign w_full        = (r_count == LP_DEPTH);
  assign w_wr_in_range = (wr_x < LP_RES_X) && (wr_y < LP_RES_Y);
  assign w_push        = wr_valid && !w_full && w_wr_in_range;
  assign w_drop        = wr_valid && (w_full || !w_wr_in_range);
  assign w_pop         = !w_rd_req && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_valid   <= 1'b0;
      r_in_active  <= 1'b0;
      r_in_x       <= '0;
      r_in_y       <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_hit     <= 1'b0;
      r_s1_x       <= '0;
      r_s1_y       <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_hit     <= 1'b0;
      r_vdl_v      <= '0;
      r_vdl_h      <= '0;
      r_resp_ready <= 1'b0;
      r_resp_skip  <= 1'b0;
      r_resp_pixel <= '0;
    end else begin
      r_in_valid   <= req_valid;
      r_in_active  <= req_active;
      r_in_x       <= req_x;
      r_in_y       <= req_y;
      r_s1_valid   <= r_in_valid;
      r_s1_hit     <= w_in_hit;
      r_s1_x       <= r_in_x[PRECISION-1:0];
      r_s1_y       <= r_in_y[PRECISION-1:0];
      r_s2_valid   <= r_s1_valid;
      r_s2_hit     <= r_s1_valid && r_s1_hit;
      r_vdl_v      <= {r_vdl_v[LP_DL-2:0], r_s2_valid};
      r_vdl_h      <= {r_vdl_h[LP_DL-2:0], r_s2_hit};
      r_resp_ready <= r_vdl_v[LP_DL-1];
      r_resp_skip  <= r_vdl_v[LP_DL-1] && !r_vdl_h[LP_DL-1];
      r_resp_pixel <= (r_vdl_v[LP_DL-1] && r_vdl_h[LP_DL-1]) ? r_ddl[LP_DD-1] : '0;
    end
  end

  // Data line carries no control, so it is left unreset; the pixel is gated by the hit line.
  always_ff @(posedge clk) begin
    r_ddl[0] <= sram_rdata;
    for (int i = 1; i < LP_DD; i++) r_ddl[i] <= r_ddl[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sram_addr  <= '0;
      r_sram_oe    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_wdata <= '0;
    end else if (w_rd_req) begin
      r_sram_addr  <= w_rd_addr;
      r_sram_oe    <= 1'b1;
      r_sram_we    <= 1'b0;
    end else if (w_pop) begin
      r_sram_addr  <= r_fifo_addr[r_rptr];
      r_sram_wdata <= r_fifo_data[r_rptr];
      r_sram_oe    <= 1'b0;
      r_sram_we    <= 1'b1;
    end else begin
      r_sram_oe    <= 1'b0;
      r_sram_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= w_wr_addr;
      r_fifo_data[r_wptr] <= wr_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + LP_PTR_1;
      if (w_pop)  r_rptr <= r_rptr + LP_PTR_1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_1;
        2'b01:   r_count <= r_count - LP_CNT_1;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign resp_ready    = r_resp_ready;
  assign resp_skip     = r_resp_skip;
  assign resp_pixel    = r_resp_pixel;
  assign wr_ready      = !w_full;
  assign wr_drop_count = r_drop_cnt;
  assign sram_addr     = r_sram_addr;
  assign sram_oe       = r_sram_oe;
  assign sram_we       = r_sram_we;
  assign sram_wdata    = r_sram_wdata;

endmodule

// File: tb/tb_fg_fetch_responder.sv
// Directed bench for fg_fetch_responder with a behavioural 2-cycle SRAM.
module tb_fg_fetch_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_active = 1'b0;
  logic [11:0] req_x = '0, req_y = '0;
  logic        resp_ready, resp_skip;
  logic [15:0] resp_pixel;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [10:0] wr_x = '0, wr_y = '0;
  logic [15:0] wr_pixel = '0;
  logic [15:0] wr_drop_count;
  logic [18:0] sram_addr;
  logic        sram_oe, sram_we;
  logic [15:0] sram_wdata, sram_rdata;

  logic [15:0] mem [0:(1<<19)-1];
  logic [15:0] r_rd;
  logic        pl_en = 1'b0;
  logic [18:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fg_fetch_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_active(req_active), .req_x(req_x), .req_y(req_y),
    .resp_ready(resp_ready), .resp_skip(resp_skip), .resp_pixel(resp_pixel),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_pixel(wr_pixel), .wr_drop_count(wr_drop_count),
    .sram_addr(sram_addr), .sram_oe(sram_oe), .sram_we(sram_we),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Address registered at edge N is read at N+1, so data is sampled by the DUT at N+2.
  always @(posedge clk) begin
    if (sram_we)    mem[sram_addr] <= sram_wdata;
    else if (pl_en) mem[pl_addr]   <= pl_data;
    r_rd <= mem[sram_addr];
  end
  assign sram_rdata = r_rd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [18:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic [11:0] x, input logic [11:0] y,
                        input logic act, input logic exp_hit,
                        input logic [18:0] exp_addr, input logic [15:0] exp_pix);
    req_valid = 1'b1; req_active = act; req_x = x; req_y = y;
    tick();                                  // E
    req_valid = 1'b0; req_active = 1'b0;
    tick();                                  // E+1
    chk({tag, "_oe_e1"}, 32'(sram_oe), 32'd0);
    tick();                                  // E+2
    chk({tag, "_oe_e2"}, 32'(sram_oe), 32'(exp_hit));
    chk({tag, "_we_e2"}, 32'(sram_we), 32'd0);
    if (exp_hit) chk({tag, "_addr"}, 32'(sram_addr), 32'(exp_addr));
    tick(); tick(); tick();                  // E+5
    chk({tag, "_rdy_e5"}, 32'(resp_ready), 32'd0);
    tick();                                  // E+6
    chk({tag, "_rdy_e6"}, 32'(resp_ready), 32'd1);
    chk({tag, "_skip"}, 32'(resp_skip), 32'(!exp_hit));
    chk({tag, "_pix"}, 32'(resp_pixel), 32'(exp_pix));
    tick();                                  // E+7
    chk({tag, "_rdy_e7"}, 32'(resp_ready), 32'd0);
  endtask

  initial begin
    logic        overlap;
    logic        any_bad;
    int          npulse;
    logic [18:0] exp_wa [0:7];

    // Reset, with SRAM preload done while held in reset
    rst = 1'b1;
    preload(19'd0, 16'hF800);
    preload(19'd479999, 16'h1234);
    for (int i = 0; i < 20; i++) preload(19'(800 + i), 16'(16'hA000 + i));
    chk("rst_ready", 32'(resp_ready), 32'd0);
    chk("rst_skip", 32'(resp_skip), 32'd0);
    chk("rst_pixel", 32'(resp_pixel), 32'd0);
    chk("rst_oe", 32'(sram_oe), 32'd0);
    chk("rst_we", 32'(sram_we), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_wdata", 32'(sram_wdata), 32'd0);
    chk("rst_drop", 32'(wr_drop_count), 32'd0);
    rst = 1'b0;
    tick(); tick();

    // Single requests: corners, out-of-range, negative, inactive
    do_req("origin", 12'd0, 12'd0, 1'b1, 1'b1, 19'd0, 16'hF800);
    do_req("corner", 12'd799, 12'd599, 1'b1, 1'b1, 19'd479999, 16'h1234);
    do_req("x800", 12'd800, 12'd0, 1'b1, 1'b0, 19'd0, 16'h0000);
    do_req("xneg", 12'hFFF, 12'd0, 1'b1, 1'b0, 19'd0, 16'h0000);
    do_req("y600", 12'd0, 12'd600, 1'b1, 1'b0, 19'd0, 16'h0000);
    do_req("yneg", 12'd3, 12'hFFE, 1'b1, 1'b0, 19'd0, 16'h0000);
    do_req("inact", 12'd0, 12'd0, 1'b0, 1'b0, 19'd0, 16'h0000);

    // 20 back-to-back requests, active on even slots
    overlap = 1'b0;
    for (int t = 0; t < 28; t++) begin
      req_valid  = (t < 20);
      req_active = (t < 20) && (t % 2 == 0);
      req_x      = 12'(t);
      req_y      = 12'd1;
      tick();
      if (sram_oe && sram_we) overlap = 1'b1;
      if (t >= 6 && t < 26) begin
        chk($sformatf("burst_rdy%0d", t-6), 32'(resp_ready), 32'd1);
        chk($sformatf("burst_skip%0d", t-6), 32'(resp_skip), 32'((t-6) % 2));
        chk($sformatf("burst_pix%0d", t-6), 32'(resp_pixel),
            ((t-6) % 2 == 0) ? 32'(16'hA000 + (t-6)) : 32'd0);
      end else begin
        chk($sformatf("burst_idle%0d", t), 32'(resp_ready), 32'd0);
      end
    end
    req_valid = 1'b0; req_active = 1'b0;
    chk("burst_overlap", 32'(overlap), 32'd0);

    // Nine writes against a saturated read bus
    any_bad = 1'b0;
    for (int t = 0; t < 13; t++) begin
      req_valid = 1'b1; req_active = 1'b1; req_x = 12'd0; req_y = 12'd0;
      wr_valid  = (t >= 4);
      wr_x      = 11'(10 + t - 4);
      wr_y      = 11'd2;
      wr_pixel  = 16'(16'h5A00 + t - 4);
      if (t >= 4) begin
        exp_wa[(t-4) % 8] = (t - 4 < 8) ? 19'(1600 + 10 + t - 4) : exp_wa[(t-4) % 8];
        chk($sformatf("wr_ready_k%0d", t-4), 32'(wr_ready), (t - 4 < 8) ? 32'd1 : 32'd0);
      end
      tick();
      if (sram_we) any_bad = 1'b1;
    end
    chk("sat_no_we", 32'(any_bad), 32'd0);
    chk("sat_drop", 32'(wr_drop_count), 32'd1);
    req_valid = 1'b0; req_active = 1'b0; wr_valid = 1'b0;

    npulse = 0;
    overlap = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (sram_oe && sram_we) overlap = 1'b1;
      if (sram_we) begin
        if (npulse < 8) begin
          chk($sformatf("drain_addr%0d", npulse), 32'(sram_addr), 32'(exp_wa[npulse]));
          chk($sformatf("drain_data%0d", npulse), 32'(sram_wdata), 32'(16'h5A00 + npulse));
        end
        npulse++;
      end
    end
    chk("drain_pulses", 32'(npulse), 32'd8);
    chk("drain_overlap", 32'(overlap), 32'd0);
    chk("drain_ready", 32'(wr_ready), 32'd1);
    for (int k = 0; k < 8; k++)
      do_req($sformatf("rb%0d", k), 12'(10 + k), 12'd2, 1'b1, 1'b1,
             19'(1610 + k), 16'(16'h5A00 + k));

    // Reset in flight: two requests plus a queued write are discarded
    req_valid = 1'b1; req_active = 1'b1; req_x = 12'd0; req_y = 12'd0;
    tick();                                  // E
    wr_valid = 1'b1; wr_x = 11'd7; wr_y = 11'd7; wr_pixel = 16'hBEEF;
    tick();                                  // E+1
    req_valid = 1'b0; req_active = 1'b0; wr_valid = 1'b0;
    tick(); tick();                          // E+3
    rst = 1'b1;
    tick();                                  // E+4
    rst = 1'b0;
    chk("mid_rst_drop", 32'(wr_drop_count), 32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    any_bad = 1'b0;
    overlap = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (resp_ready) any_bad = 1'b1;
      if (sram_we) overlap = 1'b1;
    end
    chk("mid_rst_no_resp", 32'(any_bad), 32'd0);
    chk("mid_rst_fifo_empty", 32'(overlap), 32'd0);

    // Out-of-range y write, then saturation with x=900
    wr_valid = 1'b1; wr_x = 11'd5; wr_y = 11'd600; wr_pixel = 16'h1111;
    tick();
    wr_valid = 1'b0;
    chk("y600_drop", 32'(wr_drop_count), 32'd1);
    wr_valid = 1'b1; wr_x = 11'd900; wr_y = 11'd0;
    any_bad = 1'b0;
    for (int i = 1; i <= 70000; i++) begin
      tick();
      if (sram_we) any_bad = 1'b1;
      if (i == 65533) chk("sat_fffe", 32'(wr_drop_count), 32'h0000FFFE);
      if (i == 65534) chk("sat_ffff", 32'(wr_drop_count), 32'h0000FFFF);
    end
    wr_valid = 1'b0;
    chk("sat_final", 32'(wr_drop_count), 32'h0000FFFF);
    chk("sat_no_we_long", 32'(any_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
